// File: rtl/shared_unit_arbiter_if.sv
// Requester and unit-side bundle for the shared unit arbiter.
// The arbiter connects through master, the requesters and unit through slave.
interface shared_unit_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    unit_valid;
    logic [DATA_W-1:0]       unit_data;
    logic                    unit_ready;
    logic                    unit_done;
    logic [IW-1:0]           grant_id;
    logic                    busy;
    logic                    timeout_err;
    logic                    err_clr;

    modport master (
        input  req,
        input  req_data,
        input  unit_ready,
        input  unit_done,
        input  err_clr,
        output gnt,
        output unit_valid,
        output unit_data,
        output grant_id,
        output busy,
        output timeout_err
    );

    modport slave (
        output req,
        output req_data,
        output unit_ready,
        output unit_done,
        output err_clr,
        input  gnt,
        input  unit_valid,
        input  unit_data,
        input  grant_id,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/shared_unit_arbiter.sv
// Round-robin arbiter sharing one processing unit between N_REQ requesters,
// with issue handshake, completion wait and a sticky watchdog timeout flag.
module shared_unit_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shared_unit_arbiter_if.master bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_e;

    state_e            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [IW-1:0]     grant_id_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic              err_q;
    logic [WW-1:0]     wd_q;

    logic [IW-1:0]     win;
    logic              win_vld;
    logic [DATA_W-1:0] win_data;
    logic              hs;
    logic              wd_lim;

    // Scan from ptr upward with wrap; lowest offset is assigned last and wins.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        idx     = 0;
        cand    = '0;
        win     = ptr_q;
        win_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = IW'(idx);
            if (bus.req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IW'(i)) begin
                win_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_d  = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    assign hs     = (state_q == ISSUE) && valid_q && bus.unit_ready;
    assign wd_lim = (wd_q == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            wd_q       <= '0;
        end else begin
            // A timeout below overrides a simultaneous clear.
            if (bus.err_clr) begin
                err_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (win_vld) begin
                        data_q     <= win_data;
                        grant_id_q <= win;
                        ptr_q      <= ptr_d;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        valid_q <= 1'b0;
                        wd_q    <= '0;
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.unit_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (wd_lim) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = hs ? (N_REQ'(1) << grant_id_q) : '0;
    assign bus.unit_valid  = valid_q;
    assign bus.unit_data   = data_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Scenario bench for shared_unit_arbiter: expected grants are queued at
// stimulus time and popped when the arbiter pulses gnt.
module tb_shared_unit_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    shared_unit_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    shared_unit_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    function automatic exp_t mk(input int id, input int data);
        exp_t e;
        e.id   = IW'(id);
        e.data = DW'(data);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.gnt != '0) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic finish_txn(input int id);
        bus.req[id] = 1'b0;
        step();
        bus.unit_done = 1'b1;
        step();
        bus.unit_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.req        = '0;
        bus.req_data   = '0;
        bus.unit_ready = 1'b0;
        bus.unit_done  = 1'b0;
        bus.err_clr    = 1'b0;
        repeat (2) step();
        n_checks++;
        if (bus.unit_valid !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== '0 ||
            bus.grant_id !== '0 || bus.unit_data !== '0 || bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b busy=%b gnt=%b id=%0d data=%h err=%b, required all 0",
                     bus.unit_valid, bus.busy, bus.gnt, bus.grant_id, bus.unit_data, bus.timeout_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus.unit_ready = 1'b1;
        bus.unit_done  = 1'b1;
        step();
        n_checks++;
        if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.unit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: gnt=%b busy=%b valid=%b, required 0000/0/0",
                     bus.gnt, bus.busy, bus.unit_valid);
        end
        bus.unit_ready = 1'b0;
        bus.unit_done  = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        bit            ok;
        exp_t          e;
        logic [N-1:0]  seen;
        seen         = '0;
        bus.req_data = 32'h4433_2211;
        for (int t = 0; t < 5; t++) sb.push_back(mk(t % 4, 8'h11 * ((t % 4) + 1)));
        bus.unit_ready = 1'b1;
        bus.req        = 4'hF;
        step();
        for (int t = 0; t < 5; t++) begin
            wait_gnt(ok);
            e = sb.pop_front();
            if (t < 4) seen = seen | bus.gnt;
            n_checks++;
            if (!ok || bus.gnt !== (4'b0001 << e.id) || bus.grant_id !== e.id ||
                bus.unit_data !== e.data) begin
                n_fail++;
                $display("FAIL rr_%0d: ok=%b gnt=%b id=%0d data=%h, required gnt=%b id=%0d data=%h",
                         t, ok, bus.gnt, bus.grant_id, bus.unit_data,
                         4'b0001 << e.id, e.id, e.data);
            end
            finish_txn(int'(e.id));
            bus.req = (t < 4) ? 4'hF : 4'h0;
        end
        n_checks++;
        if (seen !== 4'hF) begin
            n_fail++;
            $display("FAIL rr_fair: served mask=%b, required 1111", seen);
        end
    endtask

    task automatic test_single();
        exp_t e;
        bus.req_data   = 32'h0000_0000;
        bus.req_data[23:16] = 8'hA5;
        bus.req        = 4'b0100;
        bus.unit_ready = 1'b1;
        sb.push_back(mk(2, 8'hA5));
        step();
        e = sb.pop_front();
        n_checks++;
        if (bus.unit_valid !== 1'b1 || bus.gnt !== 4'b0100 || bus.grant_id !== e.id ||
            bus.unit_data !== e.data || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_issue: valid=%b gnt=%b id=%0d data=%h busy=%b, required 1/0100/%0d/%h/1",
                     bus.unit_valid, bus.gnt, bus.grant_id, bus.unit_data, bus.busy, e.id, e.data);
        end
        bus.req = '0;
        step();
        n_checks++;
        if (bus.unit_valid !== 1'b0 || bus.gnt !== '0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_wait: valid=%b gnt=%b busy=%b, required 0/0000/1",
                     bus.unit_valid, bus.gnt, bus.busy);
        end
        step();
        step();
        bus.unit_done = 1'b1;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_done: busy=%b, required 1", bus.busy);
        end
        step();
        bus.unit_done = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.unit_valid !== 1'b0 || bus.grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_end: busy=%b valid=%b id=%0d, required 0/0/2",
                     bus.busy, bus.unit_valid, bus.grant_id);
        end
    endtask

    task automatic test_wrap_skip();
        bit   ok;
        exp_t e;
        bus.req_data = 32'hC300_0000;
        bus.req      = 4'b1000;
        sb.push_back(mk(3, 8'hC3));
        step();
        wait_gnt(ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || bus.gnt !== 4'b1000 || bus.grant_id !== e.id || bus.unit_data !== e.data) begin
            n_fail++;
            $display("FAIL wrap_3: ok=%b gnt=%b id=%0d data=%h, required 1000/%0d/%h",
                     ok, bus.gnt, bus.grant_id, bus.unit_data, e.id, e.data);
        end
        finish_txn(3);
        bus.req_data = 32'h00A6_005A;
        bus.req      = 4'b0101;
        sb.push_back(mk(0, 8'h5A));
        sb.push_back(mk(2, 8'hA6));
        for (int t = 0; t < 2; t++) begin
            wait_gnt(ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || bus.gnt !== (4'b0001 << e.id) || bus.grant_id !== e.id ||
                bus.unit_data !== e.data) begin
                n_fail++;
                $display("FAIL skip_%0d: ok=%b gnt=%b id=%0d data=%h, required id=%0d data=%h",
                         t, ok, bus.gnt, bus.grant_id, bus.unit_data, e.id, e.data);
            end
            finish_txn(int'(e.id));
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        bus.unit_ready = 1'b0;
        bus.req_data   = 32'h0000_3C00;
        bus.req        = 4'b0010;
        sb.push_back(mk(1, 8'h3C));
        step();
        bus.req      = '0;
        bus.req_data = '0;
        for (int t = 0; t < 5; t++) begin
            n_checks++;
            if (bus.unit_valid !== 1'b1 || bus.unit_data !== 8'h3C || bus.gnt !== '0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: valid=%b data=%h gnt=%b, required 1/3c/0000",
                         t, bus.unit_valid, bus.unit_data, bus.gnt);
            end
            step();
        end
        bus.unit_ready = 1'b1;
        #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.gnt !== 4'b0010 || bus.grant_id !== e.id || bus.unit_data !== e.data) begin
            n_fail++;
            $display("FAIL bp_accept: gnt=%b id=%0d data=%h, required 0010/%0d/%h",
                     bus.gnt, bus.grant_id, bus.unit_data, e.id, e.data);
        end
        finish_txn(1);
    endtask

    task automatic test_timeout();
        bit   ok;
        bit   early;
        exp_t e;
        bus.unit_ready = 1'b1;
        bus.req_data   = 32'h0000_0077;
        // Transaction 1: plain timeout.
        bus.req = 4'b0001;
        sb.push_back(mk(0, 8'h77));
        step();
        wait_gnt(ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || bus.grant_id !== e.id || bus.unit_data !== e.data) begin
            n_fail++;
            $display("FAIL to_issue: ok=%b id=%0d data=%h, required %0d/%h",
                     ok, bus.grant_id, bus.unit_data, e.id, e.data);
        end
        bus.req = '0;
        step();
        early = 1'b0;
        for (int k = 0; k < TO; k++) begin
            if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) early = 1'b1;
            step();
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: flag or idle seen before %0d cycles, required none", TO);
        end
        n_checks++;
        if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0 || bus.unit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL to_fire: err=%b busy=%b valid=%b, required 1/0/0",
                     bus.timeout_err, bus.busy, bus.unit_valid);
        end
        // Transaction 2: clear coincides with a new timeout.
        bus.req = 4'b0001;
        sb.push_back(mk(0, 8'h77));
        step();
        wait_gnt(ok);
        e = sb.pop_front();
        bus.req = '0;
        step();
        for (int k = 0; k < TO - 1; k++) step();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        n_checks++;
        if (!ok || bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clr_race: ok=%b err=%b busy=%b, required 1/1/0",
                     ok, bus.timeout_err, bus.busy);
        end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        n_checks++;
        if (bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clear: err=%b, required 0", bus.timeout_err);
        end
        // Transaction 3: done lands on the watchdog limit cycle.
        bus.req = 4'b0001;
        sb.push_back(mk(0, 8'h77));
        step();
        wait_gnt(ok);
        e = sb.pop_front();
        bus.req = '0;
        step();
        for (int k = 0; k < TO - 1; k++) step();
        bus.unit_done = 1'b1;
        step();
        bus.unit_done = 1'b0;
        n_checks++;
        if (!ok || bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_done_limit: ok=%b err=%b busy=%b, required 1/0/0",
                     ok, bus.timeout_err, bus.busy);
        end
    endtask

    task automatic test_async_reset();
        bit   ok;
        exp_t e;
        bus.unit_ready = 1'b1;
        bus.req_data   = 32'h0099_0000;
        bus.req        = 4'b0100;
        sb.push_back(mk(2, 8'h99));
        step();
        wait_gnt(ok);
        e = sb.pop_front();
        bus.req = '0;
        step();
        n_checks++;
        if (!ok || bus.busy !== 1'b1 || bus.grant_id !== e.id) begin
            n_fail++;
            $display("FAIL ar_pre: ok=%b busy=%b id=%0d, required 1/1/%0d",
                     ok, bus.busy, bus.grant_id, e.id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.unit_valid !== 1'b0 || bus.grant_id !== '0 ||
            bus.gnt !== '0) begin
            n_fail++;
            $display("FAIL ar_immediate: busy=%b valid=%b id=%0d gnt=%b, required 0/0/0/0000",
                     bus.busy, bus.unit_valid, bus.grant_id, bus.gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus.req_data = 32'h5500_6600;
        bus.req      = 4'b1010;
        sb.push_back(mk(1, 8'h66));
        wait_gnt(ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || bus.gnt !== 4'b0010 || bus.grant_id !== e.id || bus.unit_data !== e.data) begin
            n_fail++;
            $display("FAIL ar_restart: ok=%b gnt=%b id=%0d data=%h, required 0010/%0d/%h",
                     ok, bus.gnt, bus.grant_id, bus.unit_data, e.id, e.data);
        end
        finish_txn(1);
        bus.req = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_wrap_skip();
        test_backpressure();
        test_timeout();
        test_async_reset();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/shared_unit_arbiter.md
Name: shared_unit_arbiter

Overview:
Round-robin arbiter and sequencer that shares one downstream processing unit between N_REQ requesters. It picks a winner, holds the winner's payload, and issues it to the unit with a valid/ready handshake. It then waits for the unit's completion pulse before arbitrating again. A watchdog aborts a transaction whose completion never arrives and flags the fault.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_W, 8, payload width per requester
TIMEOUT, 16, max cycles in WAIT_DONE before abort (>=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester request; held high with stable payload until own gnt bit pulses
req_data  input  N_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W]
gnt  output  N_REQ  one-hot, one-cycle pulse in the cycle requester's payload is accepted by unit
unit_valid  output  1  payload valid to unit
unit_data  output  DATA_W  latched winner payload
unit_ready  input  1  unit accepts payload when high with unit_valid
unit_done  input  1  one-cycle completion pulse from unit
grant_id  output  $clog2(N_REQ)  index of current or last winner
busy  output  1  high in ISSUE and WAIT_DONE
timeout_err  output  1  sticky watchdog flag
err_clr  input  1  synchronous clear of timeout_err

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr pointer=0, gnt=0, unit_valid=0, unit_data=0, grant_id=0, busy=0, timeout_err=0, watchdog=0.
- Reset mid-transaction drops unit_valid immediately. No gnt is produced for the aborted transaction.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE, any req bit high:
  - Winner = first set bit scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
  - Next edge latches winner payload into unit_data, winner into grant_id, sets unit_valid=1, and goes to ISSUE.
  - Pointer updates to (winner+1) mod N_REQ at the same edge.
- IDLE, no req: hold state; outputs unchanged except unit_valid=0.
- ISSUE: unit_valid=1 and unit_data stable until accepted.
  - In the cycle unit_valid&&unit_ready, gnt[grant_id]=1 (combinational from handshake).
  - Next edge: unit_valid=0, watchdog=0, go to WAIT_DONE.
  - A requester deasserting req during ISSUE does not cancel the issue; the latched payload is still sent.
- WAIT_DONE: watchdog increments each cycle.
  - unit_done=1: go to IDLE next edge. Earliest re-issue is 2 cycles after the done cycle.
  - watchdog reaches TIMEOUT-1 without done: set timeout_err, go to IDLE.
  - unit_done in the same cycle as the watchdog limit counts as completion: no error.
- unit_done in IDLE or ISSUE is ignored.
- unit_ready in IDLE or WAIT_DONE is ignored.
- err_clr clears timeout_err next edge. A simultaneous new timeout wins: flag stays set.
- gnt is never asserted outside the ISSUE handshake cycle and is never multi-hot.
- Minimum latency: req high in cycle 0 -> unit_valid in cycle 1 -> gnt in cycle 1 if unit_ready=1.
- Fairness: with all requesters continuously requesting, each is served once per N_REQ transactions.

Test Plan:
- Single request: req=4'b0100, req_data[23:16]=8'hA5, unit_ready=1, done 3 cycles after accept -> unit_valid cycle 1, unit_data=8'hA5, grant_id=2, gnt=4'b0100 for one cycle, busy high until done+1.
- Round robin: req=4'b1111 held, each requester drops its req after its own gnt then re-raises; immediate ready/done -> winner order 0,1,2,3,0; no requester served twice before all are served.
- Wrap and skip: after a winner of 3, req=4'b0101 -> winner 0, next winner 2.
- Backpressure: unit_ready=0 for 5 cycles -> unit_valid and unit_data stable, gnt=0 throughout; gnt pulses only in the ready cycle.
- Timeout: unit_done never asserted -> timeout_err=1 exactly TIMEOUT=16 cycles after entering WAIT_DONE, state IDLE; err_clr pulse -> timeout_err=0 next cycle.
- Async reset in WAIT_DONE: rst_n low between edges -> busy=0, unit_valid=0, grant_id=0 immediately; no gnt; first arbitration after release starts at requester 0.
